// File: rtl/sobel_mag_sqrt.sv
// ============================================================================
// sobel_mag_sqrt : Sobel gradient magnitude, floor(sqrt(gx2+gy2)) clamped to a
//                  pixel; optional binary edge map under SOBEL_MAG_THRESH_EN.
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module sobel_mag_sqrt #(
  parameter int IN_W   = 20,
  parameter int ROOT_W = 11,
  parameter int OUT_W  = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  gx2,
  input  logic [IN_W-1:0]  gy2,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SOBEL_MAG_THRESH_EN
  input  logic [OUT_W-1:0] thresh,
`endif
  output logic [OUT_W-1:0] out_data
);

  localparam int SUM_W = 2 * ROOT_W;
  localparam int REM_W = ROOT_W + 1;
  localparam int CNT_W = $clog2(ROOT_W);
  localparam logic [ROOT_W-1:0] C_PIX_MAX = ROOT_W'((1 << OUT_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [ROOT_W-1:0]  root_q, root_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
`ifdef SOBEL_MAG_THRESH_EN
  logic [OUT_W-1:0]   thresh_q, thresh_d;
`endif

  logic [REM_W+1:0]   rem_shift;
  logic [REM_W+1:0]   trial;
  logic               trial_ok;
  logic [ROOT_W-1:0]  root_next;
  logic [OUT_W-1:0]   root_clamped;
  logic [OUT_W-1:0]   result;
  logic               accept;

  // rem never exceeds 2*root, so REM_W bits hold it between steps without loss
  assign rem_shift    = {rem_q, sum_q[SUM_W-1 -: 2]};
  assign trial        = {1'b0, root_q, 2'b01};
  assign trial_ok     = (rem_shift >= trial);
  assign root_next    = {root_q[ROOT_W-2:0], trial_ok};
  assign root_clamped = (root_next > C_PIX_MAX) ? {OUT_W{1'b1}} : root_next[OUT_W-1:0];

`ifdef SOBEL_MAG_THRESH_EN
  assign result = (root_clamped >= thresh_q) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
`else
  assign result = root_clamped;
`endif

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    rem_d      = rem_q;
    root_d     = root_q;
    count_d    = count_q;
    out_data_d = out_data_q;
`ifdef SOBEL_MAG_THRESH_EN
    thresh_d   = thresh_q;
`endif
    case (state_q)
      S_CALC: begin
        sum_d   = {sum_q[SUM_W-3:0], 2'b00};
        rem_d   = trial_ok ? REM_W'(rem_shift - trial) : REM_W'(rem_shift);
        root_d  = root_next;
        count_d = count_q - CNT_W'(1);
        if (count_q == '0) begin
          state_d    = S_DONE;
          out_data_d = result;
        end
      end
      S_DONE: begin
        if (out_ready && !in_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Shared load path: IDLE accept, or DONE retiring and accepting in one cycle
    if (accept) begin
      state_d = S_CALC;
      sum_d   = {{(SUM_W-IN_W){1'b0}}, gx2} + {{(SUM_W-IN_W){1'b0}}, gy2};
      rem_d   = '0;
      root_d  = '0;
      count_d = CNT_W'(ROOT_W - 1);
`ifdef SOBEL_MAG_THRESH_EN
      thresh_d = thresh;
`endif
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= S_IDLE;
      sum_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      count_q    <= '0;
      out_data_q <= '0;
`ifdef SOBEL_MAG_THRESH_EN
      thresh_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
`ifdef SOBEL_MAG_THRESH_EN
      thresh_q   <= thresh_d;
`endif
    end
  end

endmodule

`default_nettype wire
